// File: rtl/sqrt_seq_param.sv
// Iterative non-restoring integer square root: root = floor(sqrt(radicand)), remainder = radicand - root^2.
// One root bit per clock, start/done handshake; `SQRT_ROUND_EN rounds root to nearest (saturating).
module sqrt_seq_param #(
   parameter int RADICAND_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [RADICAND_WIDTH-1:0]     radicand,
   output logic                          busy,
   output logic                          done,
   output logic [RADICAND_WIDTH/2-1:0]   root,
   output logic [RADICAND_WIDTH/2:0]     remainder
);

   localparam int ROOT_WIDTH = RADICAND_WIDTH / 2;
   localparam int REM_WIDTH  = ROOT_WIDTH + 2;
   localparam int CNT_W      = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;

   generate
      if ((RADICAND_WIDTH % 2) != 0 || RADICAND_WIDTH < 4) begin : g_bad_width
         $error("sqrt_seq_param: RADICAND_WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t                    state, state_n;
   logic [RADICAND_WIDTH-1:0] operand, operand_n;
   logic [REM_WIDTH-1:0]      r, r_n;
   logic [ROOT_WIDTH-1:0]     q, q_n;
   logic [CNT_W-1:0]          count, count_n;
   logic                      busy_n, done_n;
   logic [ROOT_WIDTH-1:0]     root_n;
   logic [ROOT_WIDTH:0]       rem_n;

   // One non-restoring step on the current digit pair of the operand.
   logic [CNT_W:0]            digit_idx;
   logic [1:0]                digit;
   logic [REM_WIDTH-1:0]      r_shift;
   logic [REM_WIDTH-1:0]      r_step;
   logic [ROOT_WIDTH-1:0]     q_step;

   assign digit_idx = {count, 1'b0};
   assign digit     = operand[digit_idx +: 2];
   assign r_shift   = {r[REM_WIDTH-3:0], digit};
   assign r_step    = r[REM_WIDTH-1] ? (r_shift + {q, 2'b11})
                                     : (r_shift - {q, 2'b01});
   assign q_step    = {q[ROOT_WIDTH-2:0], ~r_step[REM_WIDTH-1]};

   // Final correction; the corrected remainder is non-negative and fits in
   // ROOT_WIDTH+1 bits, so the low bits alone give the exact result.
   logic [ROOT_WIDTH:0]       r_fix;
   logic [ROOT_WIDTH-1:0]     root_fix;

   assign r_fix = r[REM_WIDTH-1] ? (r[ROOT_WIDTH:0] + {q, 1'b1}) : r[ROOT_WIDTH:0];

`ifdef SQRT_ROUND_EN
   // remainder > floor_root means radicand > floor_root^2 + floor_root, i.e. sqrt is past the midpoint.
   assign root_fix = (r_fix > {1'b0, q}) ? ((&q) ? q : q + ROOT_WIDTH'(1)) : q;
`else
   assign root_fix = q;
`endif

   always_comb begin
      state_n   = state;
      operand_n = operand;
      r_n       = r;
      q_n       = q;
      count_n   = count;
      root_n    = root;
      rem_n     = remainder;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               operand_n = radicand;
               r_n       = '0;
               q_n       = '0;
               count_n   = CNT_W'(ROOT_WIDTH - 1);
               state_n   = ITER;
            end
         end
         ITER: begin
            r_n = r_step;
            q_n = q_step;
            if (count == '0) begin
               state_n = FIX;
            end else begin
               count_n = count - CNT_W'(1);
            end
         end
         FIX: begin
            r_n     = {1'b0, r_fix};
            root_n  = root_fix;
            rem_n   = r_fix;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         operand   <= '0;
         r         <= '0;
         q         <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         root      <= '0;
         remainder <= '0;
      end else begin
         state     <= state_n;
         operand   <= operand_n;
         r         <= r_n;
         q         <= q_n;
         count     <= count_n;
         busy      <= busy_n;
         done      <= done_n;
         root      <= root_n;
         remainder <= rem_n;
      end
   end

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Bench for sqrt_seq_param: 16-bit and 32-bit instances, vector table, corner sequences, random sweep vs. a reference model.
module tb_sqrt_seq_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        start16, start32;
   logic [15:0] rad16;
   logic [31:0] rad32;
   logic        busy16, done16, busy32, done32;
   logic [7:0]  root16;
   logic [8:0]  rem16;
   logic [15:0] root32;
   logic [16:0] rem32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sqrt_seq_param #(.RADICAND_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .radicand(rad16),
      .busy(busy16), .done(done16), .root(root16), .remainder(rem16));

   sqrt_seq_param #(.RADICAND_WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .radicand(rad32),
      .busy(busy32), .done(done32), .root(root32), .remainder(rem32));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: floor square root by binary search on plain integers.
   task automatic ref_sqrt(input longint n, input int rw, output longint r_exp, output longint rem_exp);
      longint lo, hi, mid;
      lo = 0;
      hi = (longint'(1) << rw) - 1;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= n) lo = mid;
         else hi = mid - 1;
      end
      rem_exp = n - lo * lo;
      r_exp   = lo;
`ifdef SQRT_ROUND_EN
      if (rem_exp > lo && lo < (longint'(1) << rw) - 1) r_exp = lo + 1;
`endif
   endtask

   // Start one operation at the current negedge and wait for done.
   task automatic run_op(input bit wide, input logic [31:0] n,
                         output logic [15:0] root_o, output logic [16:0] rem_o, output int lat);
      if (wide) begin start32 = 1'b1; rad32 = n; end
      else      begin start16 = 1'b1; rad16 = n[15:0]; end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start16 = 1'b0;
         start32 = 1'b0;
      end while (!(wide ? done32 : done16) && lat < 60);
      root_o = wide ? root32 : {8'h00, root16};
      rem_o  = wide ? rem32  : {8'h00, rem16};
   endtask

   typedef struct {
      logic [15:0] n;
      logic [7:0]  exp_root;
      logic [7:0]  exp_root_rnd;
      logic [8:0]  exp_rem;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [15:0] got_root;
      logic [16:0] got_rem;
      int          lat, ndone, first_done, last_done, gap;
      longint      er, erem;
      logic [31:0] rn;

      vecs[0]  = '{16'd144,   8'd12,  8'd12,  9'd0};
      vecs[1]  = '{16'd65535, 8'd255, 8'd255, 9'd510};
      vecs[2]  = '{16'd210,   8'd14,  8'd14,  9'd14};
      vecs[3]  = '{16'd211,   8'd14,  8'd15,  9'd15};
      vecs[4]  = '{16'd50000, 8'd223, 8'd224, 9'd271};
      vecs[5]  = '{16'd100,   8'd10,  8'd10,  9'd0};
      vecs[6]  = '{16'd1,     8'd1,   8'd1,   9'd1 - 9'd1};
      vecs[7]  = '{16'd2,     8'd1,   8'd1,   9'd1};
      vecs[8]  = '{16'd3,     8'd1,   8'd2,   9'd2};
      vecs[9]  = '{16'd65024, 8'd254, 8'd255, 9'd508};
      vecs[10] = '{16'd255,   8'd15,  8'd16,  9'd30};
      vecs[11] = '{16'd0,     8'd0,   8'd0,   9'd0};

      reset = 1'b1; start16 = 1'b0; start32 = 1'b0; rad16 = '0; rad32 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy16, 0);
      check("reset_done", done16, 0);
      check("reset_root", root16, 0);
      check("reset_rem",  rem16,  0);
      check("reset_busy32", busy32, 0);
      reset = 1'b0;
      @(negedge clk);

      // radicand 0: busy through the iterations, single done after 10 cycles
      start16 = 1'b1; rad16 = 16'd0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k <= 9) check($sformatf("t1_busy_c%0d", k), busy16, 1);
         check($sformatf("t1_done_c%0d", k), done16, (k == 10));
      end
      check("t1_root", root16, 0);
      check("t1_rem",  rem16,  0);
      @(negedge clk);
      check("t1_done_after", done16, 0);
      check("t1_busy_after", busy16, 0);

      // Vector table, each start issued in the done cycle of the previous op
      for (int i = 0; i < 12; i++) begin
         run_op(1'b0, {16'h0, vecs[i].n}, got_root, got_rem, lat);
`ifdef SQRT_ROUND_EN
         check($sformatf("vec%0d_root", i), got_root, vecs[i].exp_root_rnd);
`else
         check($sformatf("vec%0d_root", i), got_root, vecs[i].exp_root);
`endif
         check($sformatf("vec%0d_rem", i), got_rem, vecs[i].exp_rem);
         check($sformatf("vec%0d_lat", i), lat, 10);
      end
      @(negedge clk);
      check("done_single_pulse", done16, 0);

      // Start while busy is ignored; operand is not disturbed by radicand changes
      start16 = 1'b1; rad16 = 16'd100;
      ndone = 0; first_done = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k == 3) begin start16 = 1'b1; rad16 = 16'd9; end
         if (k == 4) start16 = 1'b0;
         if (k == 6) rad16 = 16'd12345;
         if (done16) begin
            ndone++;
            if (first_done == 0) first_done = k;
            check("t4_root", root16, 10);
            check("t4_rem",  rem16,  0);
         end
      end
      check("t4_ndone", ndone, 1);
      check("t4_done_cycle", first_done, 10);

      // Start held high: a new result every 10 cycles
      start16 = 1'b1; rad16 = 16'd144;
      ndone = 0; first_done = 0; last_done = 0; gap = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (done16) begin
            ndone++;
            if (first_done == 0) first_done = k;
            else gap = k - last_done;
            last_done = k;
         end
      end
      start16 = 1'b0;
      check("hold_ndone", ndone, 3);
      check("hold_first", first_done, 10);
      check("hold_gap", gap, 10);
      @(negedge clk);

      // Reset mid-operation aborts without done
      start16 = 1'b1; rad16 = 16'd50000;
      ndone = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start16 = 1'b0;
         if (k == 5) begin
            check("t5_busy", busy16, 0);
            check("t5_root", root16, 0);
            check("t5_rem",  rem16,  0);
            reset = 1'b0;
         end
         if (k == 4) reset = 1'b1;
         if (done16) ndone++;
      end
      check("t5_ndone", ndone, 0);

      // Reset and start together: reset wins
      reset = 1'b1; start16 = 1'b1; rad16 = 16'd144;
      @(negedge clk);
      check("rst_start_busy", busy16, 0);
      reset = 1'b0; start16 = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done16 || busy16) ndone++;
      end
      check("rst_start_idle", ndone, 0);

      run_op(1'b0, 32'd50000, got_root, got_rem, lat);
`ifdef SQRT_ROUND_EN
      check("t5_fresh_root", got_root, 224);
`else
      check("t5_fresh_root", got_root, 223);
`endif
      check("t5_fresh_rem", got_rem, 271);

      // Random 16-bit sweep against the model
      for (int i = 0; i < 40; i++) begin
         rn = $urandom_range(0, 65535);
         run_op(1'b0, rn, got_root, got_rem, lat);
         ref_sqrt(longint'(rn), 8, er, erem);
         check($sformatf("rnd16_%0d_root n=%0d", i, rn), got_root, er);
         check($sformatf("rnd16_%0d_rem n=%0d", i, rn),  got_rem,  erem);
         check($sformatf("rnd16_%0d_lat", i), lat, 10);
      end

      // 32-bit instance: all-ones and random sweep
      @(negedge clk);
      run_op(1'b1, 32'hFFFF_FFFF, got_root, got_rem, lat);
      check("w32_max_root", got_root, 65535);
      check("w32_max_rem",  got_rem,  131070);
      check("w32_max_lat",  lat,      18);
      for (int i = 0; i < 40; i++) begin
         rn = $urandom;
         run_op(1'b1, rn, got_root, got_rem, lat);
         ref_sqrt(longint'(rn), 16, er, erem);
         check($sformatf("rnd32_%0d_root n=%0d", i, rn), got_root, er);
         check($sformatf("rnd32_%0d_rem n=%0d", i, rn),  got_rem,  erem);
         check($sformatf("rnd32_%0d_lat", i), lat, 18);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
